// File: rtl/alu_sequencer_pkg.sv
//------------------------------------------------------------------------------
// alu_sequencer_pkg : opcodes, FSM encoding and helpers for the ALU sequencer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package alu_sequencer_pkg;

  localparam int ALU_OP_W = 13;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_MUL   = 4'd4;
  localparam logic [3:0] OP_DIV   = 4'd5;
  localparam logic [3:0] OP_SHR   = 4'd6;
  localparam logic [3:0] OP_SHL   = 4'd7;
  localparam logic [3:0] OP_ROR   = 4'd8;
  localparam logic [3:0] OP_ROL   = 4'd9;
  localparam logic [3:0] OP_NEG   = 4'd10;
  localparam logic [3:0] OP_NOT   = 4'd11;
  localparam logic [3:0] OP_INCPC = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_INCPC;
  endfunction

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_op_decode.sv
//------------------------------------------------------------------------------
// alu_op_decode : opcode to one-hot ALU strobe; opcodes 13-15 decode to zero
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_op_decode
  import alu_sequencer_pkg::*;
(
  input  logic [3:0]          opcode,
  output logic [ALU_OP_W-1:0] alu_op
);

  always_comb begin
    alu_op = '0;
    for (int i = 0; i < ALU_OP_W; i++) begin
      alu_op[i] = (opcode == 4'(i));
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
//------------------------------------------------------------------------------
// alu_sequencer : latches operands, strobes one ALU op for a wait count,
//                 captures the 64-bit result and pulses done
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned MULDIV_WAIT = 4,
  parameter int unsigned SIMPLE_WAIT = 1
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic [3:0]          opcode,
  input  logic [31:0]         ra_data,
  input  logic [31:0]         rb_data,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [31:0]         alu_a,
  output logic [31:0]         alu_b,
  input  logic [63:0]         alu_c,
  output logic [31:0]         z_lo,
  output logic [31:0]         z_hi,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  // A zero wait would skip EXEC entirely, so it is clamped to one cycle
  localparam logic [15:0] c_muldiv_wait = 16'((MULDIV_WAIT == 0) ? 32'd1 : MULDIV_WAIT);
  localparam logic [15:0] c_simple_wait = 16'((SIMPLE_WAIT == 0) ? 32'd1 : SIMPLE_WAIT);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_opcode;
  logic [31:0]           r_alu_a;
  logic [31:0]           r_alu_b;
  logic [31:0]           r_z_lo;
  logic [31:0]           r_z_hi;
  logic [15:0]           r_cnt;
  logic                  r_illegal;
  logic [ALU_OP_W-1:0]   w_dec;

  alu_op_decode u_decode (
    .opcode (r_opcode),
    .alu_op (w_dec)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    alu_op      = '0;
    busy        = (r_state != ST_IDLE);
    done        = (r_state == ST_DONE);
    illegal     = (r_state == ST_DONE) && r_illegal;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = is_legal(opcode) ? ST_EXEC : ST_DONE;
      end
      ST_EXEC: begin
        alu_op = w_dec;
        if (r_cnt <= 16'd1) w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        alu_op      = w_dec;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_opcode  <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_z_lo    <= '0;
      r_z_hi    <= '0;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_opcode  <= opcode;
            r_alu_a   <= ra_data;
            r_alu_b   <= rb_data;
            r_illegal <= !is_legal(opcode);
            if (!is_legal(opcode))     r_cnt <= '0;
            else if (is_muldiv(opcode)) r_cnt <= c_muldiv_wait;
            else                       r_cnt <= c_simple_wait;
          end
        end
        ST_EXEC: begin
          if (r_cnt != 16'd0) r_cnt <= r_cnt - 16'd1;
        end
        ST_CAPTURE: begin
          r_z_lo <= alu_c[31:0];
          r_z_hi <= alu_c[63:32];
        end
        default: ;
      endcase
    end
  end

  assign alu_a = r_alu_a;
  assign alu_b = r_alu_b;
  assign z_lo  = r_z_lo;
  assign z_hi  = r_z_hi;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
//------------------------------------------------------------------------------
// tb_alu_sequencer : directed self-checking bench with a behavioural ALU
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_sequencer;

  logic        clk;
  logic        clr;
  logic        start;
  logic [3:0]  opcode;
  logic [31:0] ra_data;
  logic [31:0] rb_data;
  logic [12:0] alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [63:0] alu_c;
  logic [31:0] z_lo;
  logic [31:0] z_hi;
  logic        busy;
  logic        done;
  logic        illegal;

  int n_pass  = 0;
  int n_total = 0;

  alu_sequencer #(.MULDIV_WAIT(4), .SIMPLE_WAIT(1)) dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .opcode  (opcode),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .alu_op  (alu_op),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_c   (alu_c),
    .z_lo    (z_lo),
    .z_hi    (z_hi),
    .busy    (busy),
    .done    (done),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the Alu: same strobe order, 64-bit result
  logic [4:0] w_sh;
  always_comb begin
    w_sh  = alu_b[4:0];
    alu_c = '0;
    if (alu_op[0])  alu_c = {32'h0, alu_a & alu_b};
    if (alu_op[1])  alu_c = {32'h0, alu_a | alu_b};
    if (alu_op[2])  alu_c = {32'h0, alu_a + alu_b};
    if (alu_op[3])  alu_c = {32'h0, alu_a - alu_b};
    if (alu_op[4])  alu_c = {32'h0, alu_a} * {32'h0, alu_b};
    if (alu_op[5])  alu_c = (alu_b == 0) ? 64'h0 : {alu_a % alu_b, alu_a / alu_b};
    if (alu_op[6])  alu_c = {32'h0, alu_a >> w_sh};
    if (alu_op[7])  alu_c = {32'h0, alu_a << w_sh};
    if (alu_op[8])  alu_c = {32'h0, (alu_a >> w_sh) | (alu_a << (6'd32 - {1'b0, w_sh}))};
    if (alu_op[9])  alu_c = {32'h0, (alu_a << w_sh) | (alu_a >> (6'd32 - {1'b0, w_sh}))};
    if (alu_op[10]) alu_c = {32'h0, -alu_a};
    if (alu_op[11]) alu_c = {32'h0, ~alu_a};
    if (alu_op[12]) alu_c = {32'h0, alu_a + 32'd1};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start   = 1'b1;
    opcode  = op;
    ra_data = a;
    rb_data = b;
    tick();
    start   = 1'b0;
  endtask

  // Called in the cycle after acceptance; stops in the done cycle
  task automatic wait_done(input int limit, output int lat, output int strobes,
                           output logic [12:0] seen, output int bad);
    lat = -1; strobes = 0; seen = '0; bad = 0;
    for (int i = 0; i < limit; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      if (alu_op != '0) strobes++;
      seen = seen | alu_op;
      if (!$onehot0(alu_op) || illegal) bad++;
      tick();
    end
  endtask

  initial begin
    int lat, strobes, bad, dones;
    logic [12:0] seen;

    clr = 1'b1; start = 1'b0; opcode = '0; ra_data = '0; rb_data = '0;
    tick();
    tick();
    check("rst_busy",  64'(busy),   64'd0);
    check("rst_done",  64'(done),   64'd0);
    check("rst_alu_op", 64'(alu_op), 64'd0);
    check("rst_z", {z_hi, z_lo}, 64'd0);
    check("rst_ab", {alu_a, alu_b}, 64'd0);
    clr = 1'b0;
    tick();

    // ADD 3+4
    issue(4'd2, 32'd3, 32'd4);
    check("add_strobe", 64'(alu_op), 64'h0004);
    check("add_ab", {alu_a, alu_b}, {32'd3, 32'd4});
    wait_done(20, lat, strobes, seen, bad);
    check("add_lat", 64'(lat), 64'd2);
    check("add_strobes", 64'(strobes), 64'd2);
    check("add_onehot", 64'(bad), 64'd0);
    check("add_z", {z_hi, z_lo}, 64'd7);
    check("add_illegal", 64'(illegal), 64'd0);
    check("add_done_op", 64'(alu_op), 64'd0);
    tick();
    check("add_done_pulse", 64'(done), 64'd0);
    check("add_idle", 64'(busy), 64'd0);

    // MUL 0x10000 * 0x10000
    issue(4'd4, 32'h0001_0000, 32'h0001_0000);
    wait_done(20, lat, strobes, seen, bad);
    check("mul_lat", 64'(lat), 64'd5);
    check("mul_strobes", 64'(strobes), 64'd5);
    check("mul_seen", 64'(seen), 64'h0010);
    check("mul_z", {z_hi, z_lo}, 64'h0000_0001_0000_0000);
    tick();

    // Illegal opcode 14: Z keeps the MUL result
    issue(4'd14, 32'd5, 32'd6);
    wait_done(20, lat, strobes, seen, bad);
    check("ill_lat", 64'(lat), 64'd0);
    check("ill_strobes", 64'(strobes), 64'd0);
    check("ill_flag", 64'(illegal), 64'd1);
    check("ill_op", 64'(alu_op), 64'd0);
    check("ill_z", {z_hi, z_lo}, 64'h0000_0001_0000_0000);
    tick();
    check("ill_flag_low", 64'(illegal), 64'd0);

    // SUB 10-3 with a second start during EXEC and during DONE
    issue(4'd3, 32'd10, 32'd3);
    start = 1'b1; opcode = 4'd2; ra_data = 32'd99; rb_data = 32'd99;
    tick();
    check("sub_a_held", {alu_a, alu_b}, {32'd10, 32'd3});
    check("sub_strobe", 64'(alu_op), 64'h0008);
    tick();
    check("sub_done", 64'(done), 64'd1);
    check("sub_z", {z_hi, z_lo}, 64'd7);
    tick();
    check("sub_done_pulse", 64'(done), 64'd0);
    check("sub_ignore_done", 64'(busy), 64'd0);
    start = 1'b0;
    tick();
    check("sub_no_queue", 64'(busy), 64'd0);
    issue(4'd2, 32'd20, 32'd22);
    wait_done(20, lat, strobes, seen, bad);
    check("next_lat", 64'(lat), 64'd2);
    check("next_z", {z_hi, z_lo}, 64'd42);
    tick();

    // DIV interrupted by clr in its second EXEC cycle
    issue(4'd5, 32'd100, 32'd7);
    tick();
    check("div_strobe", 64'(alu_op), 64'h0020);
    clr = 1'b1;
    #1;
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_op", 64'(alu_op), 64'd0);
    check("clr_ab", {alu_a, alu_b}, 64'd0);
    check("clr_z", {z_hi, z_lo}, 64'd0);
    check("clr_done", 64'({done, illegal}), 64'd0);
    tick();
    clr = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) dones++;
      tick();
    end
    check("clr_no_done", 64'(dones), 64'd0);
    issue(4'd2, 32'd1, 32'd1);
    wait_done(20, lat, strobes, seen, bad);
    check("post_clr_z", {z_hi, z_lo}, 64'd2);
    tick();

    // NOT 0 then IncPC 5 back to back
    issue(4'd11, 32'd0, 32'd0);
    wait_done(20, lat, strobes, seen, bad);
    check("not_seen", 64'(seen), 64'h0800);
    check("not_onehot", 64'(bad), 64'd0);
    check("not_z", {z_hi, z_lo}, 64'h0000_0000_FFFF_FFFF);
    tick();
    issue(4'd12, 32'd5, 32'd0);
    wait_done(20, lat, strobes, seen, bad);
    check("inc_seen", 64'(seen), 64'h1000);
    check("inc_onehot", 64'(bad), 64'd0);
    check("inc_z", {z_hi, z_lo}, 64'd6);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter MULDIV_WAIT, default 4, meaning the number of EXEC cycles held for MUL and DIV.
REQ-002 The block SHALL have parameter SIMPLE_WAIT, default 1, meaning the number of EXEC cycles held for every other legal opcode.
REQ-003 The block SHALL have one clock and one reset: clk  in  1  rising-edge clock; clr  in  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port start  in  1  request, sampled only in IDLE.
REQ-005 The block SHALL have port opcode  in  4  operation select: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 MUL, 5 DIV, 6 SHR, 7 SHL, 8 ROR, 9 ROL, 10 NEG, 11 NOT, 12 IncPC, 13-15 illegal.
REQ-006 The block SHALL have ports ra_data  in  32  operand A source, and rb_data  in  32  operand B source.
REQ-007 The block SHALL have port alu_op  out  13  one-hot ALU strobes, bit index equal to the opcode value.
REQ-008 The block SHALL have ports alu_a  out  32  latched A, and alu_b  out  32  latched B.
REQ-009 The block SHALL have port alu_c  in  64  ALU result.
REQ-010 The block SHALL have ports z_lo  out  32  result low word, and z_hi  out  32  result high word.
REQ-011 The block SHALL have ports busy  out  1  not IDLE; done  out  1  one-cycle completion pulse; illegal  out  1  qualifies done, high for an illegal opcode.

Function
REQ-012 The block SHALL implement FSM states IDLE, EXEC, CAPTURE and DONE.
REQ-013 IDLE SHALL behave as follows: on the edge where start=1 (edge k), latch opcode, ra_data and rb_data; go to EXEC for a legal opcode, or to DONE with illegal set for an illegal opcode.
REQ-014 EXEC SHALL behave as follows: alu_op drives exactly one bit high, held for the wait count (MULDIV_WAIT or SIMPLE_WAIT); a down-counter loads at edge k; the state goes to CAPTURE when the count expires.
REQ-015 CAPTURE SHALL behave as follows: the strobe stays high; at the next edge z_lo takes alu_c[31:0] and z_hi takes alu_c[63:32]; the state goes to DONE.
REQ-016 DONE SHALL behave as follows: done=1 for exactly one cycle, alu_op=0, then IDLE; illegal is valid only while done=1 and is low otherwise.
REQ-017 Simple-op latency SHALL be: EXEC in the cycle after k, Z updated at edge k+2, done high in the cycle after edge k+2; MUL/DIV latency SHALL extend this by MULDIV_WAIT-SIMPLE_WAIT cycles.
REQ-018 alu_op SHALL be all zero in IDLE and DONE, and SHALL never have more than one bit set.
REQ-019 alu_a and alu_b SHALL hold their latched values from edge k until the next accepted start and SHALL be unaffected by changes on ra_data and rb_data while busy.
REQ-020 start SHALL be ignored while busy=1; no request is queued.
REQ-021 start=1 in the DONE cycle SHALL be ignored; a new request SHALL be accepted only in IDLE.
REQ-022 For an illegal opcode, z_lo and z_hi SHALL remain unchanged and no strobe SHALL be issued.
REQ-023 The block SHALL not modify alu_c; the 64-bit result SHALL be split verbatim, with no sign or zero extension applied.
REQ-024 A wait parameter of 0 SHALL be treated as 1.

Reset
REQ-025 Asserting clr at any time, including mid-EXEC, SHALL immediately force: state IDLE, alu_op=0, alu_a=0, alu_b=0, z_lo=0, z_hi=0, busy=0, done=0, illegal=0, counter=0.
REQ-026 After clr deasserts, the first rising edge with start=1 SHALL be accepted as a new request.

Structure
REQ-027 A shared package SHALL hold the opcode constants 0-12, the FSM state encoding, and ALU_OP_W=13.
REQ-028 The decode from opcode to one-hot alu_op SHALL be one sub-module, alu_op_decode, which is combinational and outputs 0 for opcodes 13-15.
REQ-029 The bench SHALL connect the sequencer to the existing Alu module using the same strobe order.

Verification
REQ-030 ADD, A=3, B=4 -> alu_op=0x0004 for 2 cycles, then z_lo=7, z_hi=0, and a single done pulse with illegal=0.
REQ-031 MUL, A=0x0001_0000, B=0x0001_0000 -> strobe bit 4 high for MULDIV_WAIT+1 cycles, then z_hi=1, z_lo=0.
REQ-032 opcode=14 -> done 1 cycle after acceptance, illegal=1, alu_op never nonzero, Z unchanged.
REQ-033 Second start during EXEC of SUB 10-3 -> ignored; z_lo=7; exactly one done pulse; the next start after IDLE is accepted.
REQ-034 clr pulsed during the 2nd EXEC cycle of DIV -> all outputs 0 within the same cycle, no done pulse, and the following ADD 1+1 gives z_lo=2.
REQ-035 Back-to-back NOT 0 then IncPC 5 -> z_lo=0xFFFF_FFFF, then the IncPC result, with strobe bits 11 and 12 each one-hot and never overlapping.
